// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable Mealy serial sequence detector (1..MAX_LEN bits, overlap selectable).
// Define SEQDET_MATCH_CNT_EN to add the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  output logic               armed,
  output logic               detect,
  output logic [CNT_W-1:0]   match_cnt
);
  typedef enum logic {IDLE, HUNT} state_t;
  state_t state, state_nx;
  logic [MAX_LEN-1:0] pat, hist, shifted, mask;
  logic [LEN_W-1:0] len, fill;
  logic [LEN_W:0] fill_p1;
  logic ovl, legal, load_ok, accepted, match;
  assign legal = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
  assign load_ok = cfg_load && legal;
  assign accepted = in_valid && state == HUNT && !cfg_load;
  assign shifted = {hist[MAX_LEN-2:0], in};
  // shifting by len == MAX_LEN yields zero, so the mask becomes all ones
  assign mask = ~({MAX_LEN{1'b1}} << len);
  assign fill_p1 = {1'b0, fill} + (LEN_W+1)'(1);
  assign match = fill_p1 >= {1'b0, len} && ((shifted ^ pat) & mask) == '0;
  assign detect = accepted && match;
  assign armed = state == HUNT;
  always_comb begin
    state_nx = load_ok ? HUNT : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat <= '0;
      len <= '0;
      ovl <= 1'b0;
      hist <= '0;
      fill <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      cfg_err <= cfg_load && !legal;
      if (load_ok) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (accepted) begin
        hist <= shifted;
        fill <= (detect && !ovl) ? '0 :
                (detect || fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
      end
    end
  end
`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load_ok) cnt <= '0;
    else if (detect && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif
endmodule
